// File: rtl/rs_sched_pkg.sv
// Shared types and helpers for the round-robin flag scheduler.
package rs_sched_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Successor of idx in a ring of n entries; wraps explicitly for any n.
    function automatic logic [3:0] rr_next(input logic [3:0] idx, input int unsigned n);
        return ((32'(idx) + 32'd1) >= n) ? 4'd0 : idx + 4'd1;
    endfunction

    // First set bit of mask searching ptr, ptr+1, ... modulo n.
    function automatic logic [3:0] rr_pick(input logic [15:0] mask, input logic [3:0] ptr,
                                           input int unsigned n);
        logic [3:0]  pick;
        logic        found;
        int unsigned j;
        pick  = 4'd0;
        found = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            j = (32'(ptr) + k) % n;
            if ((k < n) && !found && mask[j[3:0]]) begin
                pick  = j[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rs_edge_sync.sv
// Multi-stage synchronizer followed by a one-cycle rising-edge pulse.
module rs_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse_c
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            last <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse_c = sync[SYNC_STAGES-1] & ~last;

endmodule

// File: rtl/rs_flag_scheduler.sv
// Bank of edge-driven set/clear flags with optional hold timeout and a
// round-robin valid/ready server that clears each flag it hands out.
module rs_flag_scheduler
    import rs_sched_pkg::*;
#(
    parameter int unsigned N_FLAGS     = 4,
    parameter int unsigned HOLD_CYCLES = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDX_W       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_FLAGS-1:0] set_in,
    input  logic [N_FLAGS-1:0] clr_in,
    output logic [N_FLAGS-1:0] flags,
    output logic [N_FLAGS-1:0] overrun,
    input  logic               ovr_clr,
    output logic               srv_valid,
    output logic [IDX_W-1:0]   srv_idx,
    input  logic               srv_ready
);

    logic [N_FLAGS-1:0] set_p, clr_p, tmo, ack, clr_ev, avail;
    logic               off_drop;
    logic [IDX_W-1:0]   rr_ptr;
    state_t             state;

    for (genvar g = 0; g < int'(N_FLAGS); g++) begin : g_sync
        rs_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_set (
            .clk(clk), .rst_n(rst_n), .d(set_in[g]), .pulse_c(set_p[g]));
        rs_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
            .clk(clk), .rst_n(rst_n), .d(clr_in[g]), .pulse_c(clr_p[g]));
    end

    if (HOLD_CYCLES > 0) begin : g_tmr
        localparam int unsigned TMR_W = (clog2(HOLD_CYCLES) < 1) ? 1 : clog2(HOLD_CYCLES);
        logic [TMR_W-1:0] timer [N_FLAGS];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(N_FLAGS); i++) timer[i] <= '0;
            end else begin
                for (int i = 0; i < int'(N_FLAGS); i++) begin
                    if (set_p[i] || !flags[i]) timer[i] <= '0;
                    else                       timer[i] <= timer[i] + TMR_W'(1);
                end
            end
        end

        always_comb begin
            tmo = '0;
            for (int i = 0; i < int'(N_FLAGS); i++)
                tmo[i] = flags[i] && (timer[i] == TMR_W'(HOLD_CYCLES - 1));
        end
    end else begin : g_no_tmr
        assign tmo = '0;
    end

    // Per-flag clear events and the offered flag's non-ack clear.
    always_comb begin
        ack      = '0;
        off_drop = 1'b0;
        for (int i = 0; i < int'(N_FLAGS); i++) begin
            ack[i] = srv_valid && srv_ready && (srv_idx == IDX_W'(i));
            if (srv_idx == IDX_W'(i)) off_drop = clr_p[i] | tmo[i];
        end
        clr_ev = clr_p | ack | tmo;
        avail  = flags & ~clr_ev;
    end

    // Clear beats set; a set on an already-set flag is an overrun only if it survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags   <= '0;
            overrun <= '0;
        end else begin
            flags   <= (flags | set_p) & ~clr_ev;
            overrun <= (overrun & ~{N_FLAGS{ovr_clr}}) | (set_p & flags & ~clr_ev);
        end
    end

    // Offers are picked from flags that survive this cycle so a dying flag is never offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            srv_valid <= 1'b0;
            srv_idx   <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|avail) begin
                        srv_idx   <= IDX_W'(rr_pick(16'(avail), 4'(rr_ptr), N_FLAGS));
                        srv_valid <= 1'b1;
                        state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (srv_ready) begin
                        rr_ptr    <= IDX_W'(rr_next(4'(srv_idx), N_FLAGS));
                        srv_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (off_drop) begin
                        srv_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_flag_scheduler.sv
// Self-checking bench: vector table for flag/overrun updates, scoreboard for served indices.
module tb_rs_flag_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] set_in, clr_in, flags, overrun;
    logic       ovr_clr, srv_valid, srv_ready;
    logic [1:0] srv_idx;

    logic [3:0] set_h, clr_h, flags_h, ovr_h;
    logic       ovr_clr_h, valid_h, ready_h;
    logic [1:0] idx_h;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sb[$];
    int ack_cyc[$];

    typedef struct {
        logic [3:0] set;
        logic [3:0] clr;
        logic       oc;
        logic [3:0] ef;
        logic [3:0] eo;
    } vec_t;
    vec_t vecs[9];

    rs_flag_scheduler #(.N_FLAGS(4), .HOLD_CYCLES(0), .SYNC_STAGES(2), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .set_in(set_in), .clr_in(clr_in), .flags(flags),
        .overrun(overrun), .ovr_clr(ovr_clr), .srv_valid(srv_valid), .srv_idx(srv_idx),
        .srv_ready(srv_ready));

    rs_flag_scheduler #(.N_FLAGS(4), .HOLD_CYCLES(5), .SYNC_STAGES(2), .IDX_W(2)) dut_h (
        .clk(clk), .rst_n(rst_n), .set_in(set_h), .clr_in(clr_h), .flags(flags_h),
        .overrun(ovr_h), .ovr_clr(ovr_clr_h), .srv_valid(valid_h), .srv_idx(idx_h),
        .srv_ready(ready_h));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshake seen before the active edge must match the next expected index.
    initial forever begin
        @(negedge clk);
        if (rst_n && srv_valid && srv_ready) begin
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) check("unexpected_ack", 32'(srv_idx), 32'hFFFF);
            else                check("ack_idx", 32'(srv_idx), 32'(sb.pop_front()));
        end
    end

    task automatic drive(input logic [3:0] s, input logic [3:0] c, input logic oc);
        @(posedge clk);
        #1;
        set_in  = s;
        clr_in  = c;
        ovr_clr = oc;
    endtask

    task automatic drain(input string name, input int max);
        int k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [3:0] fh[20];
        logic       vh[20];
        int         cnt, fall;

        vecs[0] = '{4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000};
        vecs[2] = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010};
        vecs[3] = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000};
        vecs[4] = '{4'b0101, 4'b0000, 1'b0, 4'b0111, 4'b0000};
        vecs[5] = '{4'b0000, 4'b0011, 1'b0, 4'b0100, 4'b0000};
        vecs[6] = '{4'b1100, 4'b1000, 1'b0, 4'b0100, 4'b0100};
        vecs[7] = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100};
        vecs[8] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000};

        rst_n = 1'b0;
        set_in = '0; clr_in = '0; ovr_clr = 1'b0; srv_ready = 1'b0;
        set_h = '0;  clr_h = '0;  ovr_clr_h = 1'b0; ready_h = 1'b0;
        #22 rst_n = 1'b1;

        // Idle after reset
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_flags", 32'(flags), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_valid", 32'(srv_valid), 0);
        check("rst_idx", 32'(srv_idx), 0);
        check("rst_flags_h", 32'(flags_h), 0);
        check("rst_valid_h", 32'(valid_h), 0);

        // Flag/overrun update table, consumer never ready
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].set, vecs[v].clr, vecs[v].oc);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_flags", v), 32'(flags), 32'(vecs[v].ef));
            check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].eo));
            drive('0, '0, 1'b0);
            repeat (4) @(posedge clk);
        end
        repeat (2) @(negedge clk);
        check("table_end_valid", 32'(srv_valid), 0);

        // Single flag: SYNC_STAGES+1 latency, offer next cycle, one-cycle accept
        drive(4'b0100, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_flags", 32'(flags), 32'(4'b0100));
        check("t2_valid_early", 32'(srv_valid), 0);
        @(posedge clk);
        #1;
        srv_ready = 1'b1;
        sb.push_back(2);
        @(negedge clk);
        check("t2_valid", 32'(srv_valid), 1);
        check("t2_idx", 32'(srv_idx), 2);
        @(posedge clk);
        #1;
        srv_ready = 1'b0;
        set_in = '0;
        @(negedge clk);
        check("t2_flags_after", 32'(flags), 0);
        check("t2_valid_after", 32'(srv_valid), 0);
        check("t2_sb_empty", 32'(sb.size()), 0);
        repeat (4) @(posedge clk);

        // Asynchronous reset in the middle of an offer
        drive(4'b0010, '0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = srv_valid;
        end
        check("t6_offer_seen", 32'(seen), 1);
        #2;
        rst_n  = 1'b0;
        set_in = '0;
        #1;
        check("t6_valid_in_reset", 32'(srv_valid), 0);
        check("t6_flags_in_reset", 32'(flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        srv_ready = 1'b1;
        set_in    = 4'b1000;
        sb.push_back(3);
        drain("t6_resume_drain", 20);
        check("t6_resume_flags", 32'(flags), 0);
        drive('0, '0, 1'b0);
        srv_ready = 1'b0;
        repeat (4) @(posedge clk);

        // Burst of three with consumer always ready: 0,1,3 two cycles apart
        ack_cyc.delete();
        @(posedge clk);
        #1;
        srv_ready = 1'b1;
        set_in    = 4'b1011;
        sb.push_back(0); sb.push_back(1); sb.push_back(3);
        drain("t3_drain", 40);
        check("t3_ack_count", 32'(ack_cyc.size()), 3);
        if (ack_cyc.size() == 3) begin
            check("t3_gap01", 32'(ack_cyc[1] - ack_cyc[0]), 2);
            check("t3_gap13", 32'(ack_cyc[2] - ack_cyc[1]), 2);
        end
        check("t3_flags", 32'(flags), 0);
        drive('0, '0, 1'b0);
        repeat (4) @(posedge clk);

        // Pointer advance and wrap: serve 1, then {0,3} must go 3 before 0
        @(posedge clk);
        #1;
        set_in = 4'b0010;
        sb.push_back(1);
        drain("t3_rr1_drain", 20);
        drive('0, '0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        set_in = 4'b1001;
        sb.push_back(3); sb.push_back(0);
        drain("t3_rr2_drain", 30);
        check("t3_rr_flags", 32'(flags), 0);
        drive('0, '0, 1'b0);
        srv_ready = 1'b0;
        repeat (4) @(posedge clk);

        // Hold timeout on the HOLD_CYCLES=5 instance
        @(posedge clk);
        #1;
        set_h = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            fh[k] = flags_h;
            vh[k] = valid_h;
        end
        cnt  = 0;
        fall = -1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (fh[k][0]) cnt++;
            if (vh[k]) seen = 1'b1;
            if (k > 0 && fall < 0 && fh[k-1][0] && !fh[k][0]) fall = k;
        end
        check("t5_high_cycles", 32'(cnt), 5);
        check("t5_offer_seen", 32'(seen), 1);
        check("t5_fall_found", 32'(fall > 0), 1);
        if (fall > 0 && fall < 19) check("t5_valid_after", 32'(vh[fall+1]), 0);
        check("t5_valid_end", 32'(valid_h), 0);
        check("t5_ovr", 32'(ovr_h), 0);
        set_h = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
